// File: rtl/run_trace_monitor_pkg.sv
// Shared definitions for the run-control / trace monitor: state encoding,
// default halt sentinel and the trace index width helper.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/run_trace_monitor_if.sv
// Core-facing bus: fetched instruction, its PC, the store strobe and the hold
// signal returned to the core.
interface run_trace_monitor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic            mem_we;
  logic            cpu_hold;

  modport master (output instr, output pc, output mem_we, input cpu_hold);
  modport slave  (input instr, input pc, input mem_we, output cpu_hold);
endinterface

// File: rtl/run_trace_monitor_ram.sv
// Simple dual-port trace memory: synchronous write, registered read-first read.
module trace_ram
  import run_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  parameter int AW    = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read sees the pre-write contents when addresses collide.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/run_trace_monitor.sv
// Run-control FSM with halt sentinel, cycle watchdog, saturating counters and
// a circular (PC, instruction) history readable oldest-first.
module run_trace_monitor
  import run_ctrl_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 16,
  parameter logic [XLEN-1:0] HALT_INSTR = XLEN'(HALT_INSTR_DEFAULT),
  parameter int              MAX_CYCLES = 1024,
  parameter int              CNT_W      = 32,
  parameter int              AW         = idx_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clr,
  run_trace_monitor_if.slave   core,
  input  logic [AW-1:0]        trace_rd_idx,
  output logic                 halted,
  output logic                 timeout,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     store_count,
  output logic [AW:0]          trace_count,
  output logic [XLEN-1:0]      trace_pc,
  output logic [XLEN-1:0]      trace_instr
);

  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_CYCLES - 1);

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, st_q, st_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic             rd_valid_q;
  logic             ram_we, is_halt, hold;
  logic [AW-1:0]    rd_addr;
  logic [2*XLEN-1:0] rd_data;

  assign is_halt = (core.instr == HALT_INSTR);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    wp_d    = wp_q;
    ram_we  = 1'b0;
    hold    = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cyc_d   = '0;
          st_d    = '0;
          cnt_d   = '0;
          wp_d    = '0;
        end
      end
      ST_RUN: begin
        hold   = is_halt;
        ram_we = 1'b1;
        wp_d   = wp_q + 1'b1;
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
        if (cyc_q != '1)       cyc_d = cyc_q + 1'b1;
        // The halt cycle never commits, so its store is not counted.
        if (core.mem_we && !is_halt && st_q != '1) st_d = st_q + 1'b1;
        if (is_halt)               state_d = ST_HALTED;
        else if (cyc_q == WD_LAST) state_d = ST_TIMEOUT;
      end
      ST_HALTED, ST_TIMEOUT: begin
        if (clr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      st_q       <= '0;
      cnt_q      <= '0;
      wp_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
      rd_valid_q <= ({1'b0, trace_rd_idx} < cnt_q);
    end
  end

  // Oldest valid entry sits trace_count slots behind the write pointer.
  assign rd_addr = wp_q - cnt_q[AW-1:0] + trace_rd_idx;

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wp_q),
    .wdata ({core.pc, core.instr}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign core.cpu_hold = hold;
  assign halted        = (state_q == ST_HALTED);
  assign timeout       = (state_q == ST_TIMEOUT);
  assign state         = state_q;
  assign cycle_count   = cyc_q;
  assign store_count   = st_q;
  assign trace_count   = cnt_q;
  assign trace_pc      = rd_valid_q ? rd_data[2*XLEN-1:XLEN] : '0;
  assign trace_instr   = rd_valid_q ? rd_data[XLEN-1:0]      : '0;

endmodule

// File: tb/tb_run_trace_monitor.sv
// Directed bench: one DUT with a long watchdog budget (halt/trace/wrap checks)
// and one with MAX_CYCLES=8 (watchdog checks), driven from shared stimulus.
module tb_run_trace_monitor;

  logic        clk = 1'b0;
  logic        rst, start, clr, mem_we;
  logic [31:0] instr, pc;
  logic [3:0]  rd_idx;
  int checks = 0;
  int fails  = 0;

  logic        halted_a, timeout_a, halted_b, timeout_b;
  logic [1:0]  state_a, state_b;
  logic [31:0] cyc_a, st_a, cyc_b, st_b;
  logic [4:0]  tcnt_a, tcnt_b;
  logic [31:0] tpc_a, tins_a, tpc_b, tins_b;

  run_trace_monitor_if #(.XLEN(32)) bus_a ();
  run_trace_monitor_if #(.XLEN(32)) bus_b ();

  assign bus_a.instr  = instr;
  assign bus_a.pc     = pc;
  assign bus_a.mem_we = mem_we;
  assign bus_b.instr  = instr;
  assign bus_b.pc     = pc;
  assign bus_b.mem_we = mem_we;

  always #5 clk = ~clk;

  run_trace_monitor #(.XLEN(32), .DEPTH(16), .MAX_CYCLES(1024), .CNT_W(32)) dut_a (
    .clk (clk), .rst (rst), .start (start), .clr (clr), .core (bus_a.slave),
    .trace_rd_idx (rd_idx), .halted (halted_a), .timeout (timeout_a), .state (state_a),
    .cycle_count (cyc_a), .store_count (st_a), .trace_count (tcnt_a),
    .trace_pc (tpc_a), .trace_instr (tins_a)
  );

  run_trace_monitor #(.XLEN(32), .DEPTH(16), .MAX_CYCLES(8), .CNT_W(32)) dut_b (
    .clk (clk), .rst (rst), .start (start), .clr (clr), .core (bus_b.slave),
    .trace_rd_idx (rd_idx), .halted (halted_b), .timeout (timeout_b), .state (state_b),
    .cycle_count (cyc_b), .store_count (st_b), .trace_count (tcnt_b),
    .trace_pc (tpc_b), .trace_instr (tins_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clr = 1'b0; mem_we = 1'b0;
    instr = 32'h0; pc = 32'h0; rd_idx = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_state", state_a, 2'd0);
    chk("rst_cycle", cyc_a, 0);
    chk("rst_store", st_a, 0);
    chk("rst_tcount", tcnt_a, 0);
    chk("rst_tpc", tpc_a, 0);
    chk("rst_hold", bus_a.cpu_hold, 1'b1);
    chk("rst_halted", halted_a, 1'b0);
    chk("rst_timeout", timeout_a, 1'b0);

    // Six-cycle run ending in halt; stores on cycles 1,3,4 and in the halt cycle
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_state_run", state_a, 2'd1);
    for (int n = 0; n < 5; n++) begin
      instr = 32'h13 + n; pc = 4 * n;
      mem_we = (n == 0 || n == 2 || n == 3);
      #1;
      chk("t1_hold_run", bus_a.cpu_hold, 1'b0);
      tick();
    end
    instr = 32'hFFFF_FFFF; pc = 32'd20; mem_we = 1'b1;
    #1;
    chk("t1_hold_halt", bus_a.cpu_hold, 1'b1);
    tick();
    instr = 32'h0; mem_we = 1'b0;
    chk("t1_state", state_a, 2'd2);
    chk("t1_halted", halted_a, 1'b1);
    chk("t1_timeout", timeout_a, 1'b0);
    chk("t1_cycle", cyc_a, 6);
    chk("t1_tcount", tcnt_a, 6);
    chk("t1_store", st_a, 3);
    rd_idx = 4'd0; tick();
    chk("t1_idx0_pc", tpc_a, 0);
    chk("t1_idx0_instr", tins_a, 32'h13);
    rd_idx = 4'd5; tick();
    chk("t1_idx5_pc", tpc_a, 20);
    chk("t1_idx5_instr", tins_a, 32'hFFFF_FFFF);
    rd_idx = 4'd6; tick();
    chk("t1_idx6_pc", tpc_a, 0);
    chk("t1_idx6_instr", tins_a, 0);
    chk("t1_cycle_stable", cyc_a, 6);
    chk("t1_hold_halted", bus_a.cpu_hold, 1'b1);

    // 20 plain cycles then halt: wrap-around on A, watchdog on B
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t2_idle_a", state_a, 2'd0);
    chk("t2_idle_b", state_b, 2'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      instr = 32'h1000_0000 | n; pc = 4 * n;
      tick();
    end
    instr = 32'hFFFF_FFFF; pc = 32'd80; tick();
    instr = 32'h0;
    chk("t2_state", state_a, 2'd2);
    chk("t2_cycle", cyc_a, 21);
    chk("t2_tcount", tcnt_a, 16);
    rd_idx = 4'd0; tick();
    chk("t2_idx0_pc", tpc_a, 20);
    chk("t2_idx0_instr", tins_a, 32'h1000_0005);
    rd_idx = 4'd15; tick();
    chk("t2_idx15_pc", tpc_a, 80);
    chk("t2_idx15_instr", tins_a, 32'hFFFF_FFFF);
    chk("wd_state", state_b, 2'd3);
    chk("wd_timeout", timeout_b, 1'b1);
    chk("wd_halted", halted_b, 1'b0);
    chk("wd_cycle", cyc_b, 8);
    chk("wd_tcount", tcnt_b, 8);
    chk("wd_hold", bus_b.cpu_hold, 1'b1);

    // Halt sentinel on cycle 8 beats the watchdog
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 7; n++) begin
      instr = 32'h33; pc = 4 * n;
      tick();
    end
    instr = 32'hFFFF_FFFF; pc = 32'd28; tick();
    instr = 32'h0;
    chk("wdh_state", state_b, 2'd2);
    chk("wdh_timeout", timeout_b, 1'b0);
    chk("wdh_cycle", cyc_b, 8);

    // Reset in RUN cycle 3
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    mem_we = 1'b1; instr = 32'h13;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0; mem_we = 1'b0;
    chk("mrst_state", state_a, 2'd0);
    chk("mrst_cycle", cyc_a, 0);
    chk("mrst_store", st_a, 0);
    chk("mrst_tcount", tcnt_a, 0);

    // clr and start together in HALTED: clr wins, no new run
    start = 1'b1; tick(); start = 1'b0;
    instr = 32'hFFFF_FFFF; tick(); instr = 32'h0;
    chk("cs_halted", state_a, 2'd2);
    clr = 1'b1; start = 1'b1; tick(); clr = 1'b0; start = 1'b0;
    chk("cs_idle", state_a, 2'd0);
    chk("cs_cycle_kept", cyc_a, 1);
    tick();
    chk("cs_still_idle", state_a, 2'd0);
    chk("cs_hold", bus_a.cpu_hold, 1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
